seq_add_ctrl: RTL and testbench

SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

---
 rtl/adder_pkg.sv | 12 +
 rtl/add4c.sv | 27 ++
 rtl/seq_add_ctrl.sv | 131 +++++++++++++
 tb/tb_seq_add_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM states.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add4c.sv
// 4-bit ripple-carry adder slice with carry-in and carry-out.
module add4c
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                cout_o
);

    logic [NIBBLE_W:0] c;

    // Ripple the carry bit by bit through four full adders.
    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
        end
    end

    assign cout_o = c[NIBBLE_W];

endmodule

// File: rtl/seq_add_ctrl.sv
// Nibble-serial add/subtract unit: one add4c slice reused SLICES times,
// LSB nibble first, with the carry held in a register between cycles.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. Only one operation is in flight,
// so req_ready is low from acceptance until the response has been taken.
module seq_add_ctrl
    import adder_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NIBBLE_W*SLICES-1:0]   a,
    input  logic [NIBBLE_W*SLICES-1:0]   b,
    input  logic                         sub,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [NIBBLE_W*SLICES-1:0]   sum,
    output logic                         carry_out,
    output logic                         overflow,
    output state_e                       dbg_state_o
);

    localparam int W     = NIBBLE_W * SLICES;
    localparam int CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLICES - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q, sub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic [CNT_W+1:0]    nib_lo;
    logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
    logic                s_cout;

    // Bit offset of the current nibble (cnt * 4).
    assign nib_lo = {cnt_q, 2'b00};
    assign a_nib  = a_q[nib_lo +: NIBBLE_W];
    assign b_nib  = b_q[nib_lo +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

    add4c u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (s_nib),
        .cout_o (s_cout)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath updates: latch on accept, one nibble per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    cnt_d   = '0;
                    // Carry-in of 1 with inverted B forms A + ~B + 1 = A - B.
                    carry_d = sub;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[nib_lo +: NIBBLE_W] = s_nib;
                carry_d = s_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Same-sign operands producing an opposite-sign result.
                    ovf_d   = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (s_nib[NIBBLE_W-1] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == DONE);
    assign sum         = sum_q;
    assign carry_out   = carry_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed bench for seq_add_ctrl with SLICES=4 (16-bit operands).
module tb_seq_add_ctrl;
    import adder_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    state_e       dbg_state;

    int checks = 0;
    int errors = 0;

    seq_add_ctrl #(.SLICES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .dbg_state_o (dbg_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present one operation, scramble inputs after acceptance,
    // and wait (bounded) for resp_valid. Leaves the response untaken.
    task automatic run_op(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                          input logic sub_in, output logic rdy_before,
                          output int lat);
        @(negedge clk);
        rdy_before = req_ready;
        a = a_in;
        b = b_in;
        sub = sub_in;
        req_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            a = W'($urandom_range(0, 65535));
            b = W'($urandom_range(0, 65535));
            sub = ~sub;
            if (resp_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    // Driver: take the response with a one-cycle resp_ready pulse.
    task automatic take_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h exp 0000", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
    endtask

    // One vector: checks ready, latency, result flags and return to IDLE.
    task automatic test_vector(input string name, input logic [W-1:0] a_in,
                               input logic [W-1:0] b_in, input logic sub_in,
                               input logic [W-1:0] exp_sum, input logic exp_c,
                               input logic exp_ov);
        logic rdy;
        int   lat;
        run_op(a_in, b_in, sub_in, rdy, lat);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s_ready got %b exp 1", name, rdy); end
        checks++; if (lat != 4) begin errors++; $display("FAIL %s_latency got %0d exp 4", name, lat); end
        checks++; if (sum !== exp_sum) begin errors++; $display("FAIL %s_sum got %h exp %h", name, sum, exp_sum); end
        checks++; if (carry_out !== exp_c) begin errors++; $display("FAIL %s_carry got %b exp %b", name, carry_out, exp_c); end
        checks++; if (overflow !== exp_ov) begin errors++; $display("FAIL %s_ovf got %b exp %b", name, overflow, exp_ov); end
        take_resp();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL %s_release got valid=%b ready=%b exp valid=0 ready=1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_vectors();
        test_vector("add_basic",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        test_vector("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_vector("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        test_vector("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        test_vector("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        test_vector("sub_zero",   16'h0003, 16'h0003, 1'b1, 16'h0000, 1'b1, 1'b0);
        test_vector("add_mixed",  16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    // Response held back three cycles while inputs move; outputs must hold.
    task automatic test_hold();
        logic rdy;
        int   lat;
        run_op(16'hA5A5, 16'h1111, 1'b0, rdy, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL hold_latency got %0d exp 4", lat); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = W'($urandom_range(0, 65535));
            b = W'($urandom_range(0, 65535));
            sub = ~sub;
            req_valid = 1'b1;
            checks++; if (sum !== 16'hB6B6 || carry_out !== 1'b0 || overflow !== 1'b0) begin
                errors++; $display("FAIL hold_outputs cyc %0d got %h/%b/%b exp b6b6/0/0", i, sum, carry_out, overflow);
            end
            checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
                errors++; $display("FAIL hold_handshake cyc %0d got valid=%b ready=%b exp valid=1 ready=0", i, resp_valid, req_ready);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL hold_idle got %0d exp IDLE", dbg_state); end
    endtask

    // Back-to-back: req_valid held across the handshake; the next op is
    // accepted on the first edge spent in IDLE.
    task automatic test_back_to_back();
        logic rdy;
        int   lat;
        run_op(16'h0100, 16'h0200, 1'b0, rdy, lat);
        checks++; if (sum !== 16'h0300) begin errors++; $display("FAIL b2b_first_sum got %h exp 0300", sum); end
        @(negedge clk);
        a = 16'h1000;
        b = 16'h0001;
        sub = 1'b1;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);          // handshake edge -> IDLE
        @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL b2b_idle got %0d exp IDLE", dbg_state); end
        @(posedge clk);          // acceptance edge
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL b2b_accept got %0d exp RUN", dbg_state); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || sum !== 16'h0FFF || carry_out !== 1'b1) begin
            errors++; $display("FAIL b2b_second got valid=%b sum=%h c=%b exp 1/0fff/1", resp_valid, sum, carry_out);
        end
        take_resp();
    endtask

    // Reset in the second RUN cycle aborts without a response.
    task automatic test_reset_mid_run();
        int seen_valid;
        @(negedge clk);
        a = 16'h1234;
        b = 16'h0FFF;
        sub = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);          // acceptance
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);          // first RUN edge
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (sum !== 16'h0000 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got %h/%b/%b exp 0000/0/0", sum, carry_out, overflow);
        end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", resp_valid); end
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) seen_valid++;
        end
        checks++; if (seen_valid != 0) begin errors++; $display("FAIL abort_no_resp got %0d valid cycles exp 0", seen_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", req_ready); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL abort_state got %0d exp IDLE", dbg_state); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: guarantees termination if the run stalls.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
